// File: rtl/button_pkg.sv
// Shared definitions for the button debouncer: default sizing and the
// per-bit debounce state encoding.
package button_pkg;

    localparam int unsigned N_BTN_DEF           = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;

    // Per-bit debounce FSM states.
    typedef enum logic {
        ST_STABLE   = 1'b0,   // synchronised input agrees with the level
        ST_COUNTING = 1'b1    // synchronised input disagrees, counting
    } db_state_e;

    // Width of a counter that must hold values up to 'cycles'.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button channel: two-flop synchroniser, stability counter, debounce
// FSM, debounced level register and registered edge pulses.
module btn_debounce_bit
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_set_o,   // level goes 0->1 on the coming edge
    output logic fall_set_o    // level goes 1->0 on the coming edge
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             fall_q;
    logic             differ;
    logic             flip;

    assign differ = (sync2_q != level_q);

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking keeps this a true two-stage chain; a blocking
            // assignment would let sync2_q see the new sync1_q in the same edge.
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, counter, level and edge-pulse registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= flip &  sync2_q;
            fall_q  <= flip & ~sync2_q;
        end
    end

    // Next-state logic: count consecutive disagreeing cycles, flip the level
    // after DEBOUNCE_CYCLES of them, drop all progress on any agreement.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        flip    = 1'b0;

        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (differ) begin
                    // Counter is zero here, so this only fires when a single
                    // disagreeing cycle is enough.
                    if (cnt_q == CNT_LAST) begin
                        flip = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_COUNTING;
                    end
                end
            end
            ST_COUNTING: begin
                if (!differ) begin
                    // Glitch: the input came back before the window closed.
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    flip = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        if (flip) begin
            level_d = sync2_q;
            cnt_d   = '0;
            state_d = ST_STABLE;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rise_set_o = flip &  sync2_q;
    assign fall_set_o = flip & ~sync2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BTN raw button pads and maintains sticky, write-1-to-clear
// event flags plus a registered interrupt for the Wishbone peripheral.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [N_BTN-1:0] evt_rise_en_i,
    input  logic [N_BTN-1:0] evt_fall_en_i,
    input  logic [N_BTN-1:0] evt_clr_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_rise_o,
    output logic [N_BTN-1:0] btn_fall_o,
    output logic [N_BTN-1:0] evt_o,
    output logic             irq_o
);

    logic [N_BTN-1:0] rise_set;
    logic [N_BTN-1:0] fall_set;
    logic [N_BTN-1:0] evt_q;
    logic [N_BTN-1:0] evt_d;
    logic             irq_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_bit
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_i   (wb_rst_i),
            .btn_i      (btn_i[i]),
            .level_o    (btn_level_o[i]),
            .rise_o     (btn_rise_o[i]),
            .fall_o     (btn_fall_o[i]),
            .rise_set_o (rise_set[i]),
            .fall_set_o (fall_set[i])
        );
    end

    // Sticky flags: clear strobe drops a flag, an enabled edge sets it, and
    // the set side is applied last so a colliding event is never lost.
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i)
              | (rise_set & evt_rise_en_i)
              | (fall_set & evt_fall_en_i);
    end

    // Event flag and interrupt registers; irq trails the flags by one edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            irq_q <= |evt_q;
        end
    end

    assign evt_o = evt_q;
    assign irq_o = irq_q;

endmodule
